ex_stage_pipeline: RTL and testbench
====================================

# ex_stage_pipeline

Execute-stage slice of the 32-bit pipelined datapath. It has three parts in series:
- the ID→EX pipeline register, which captures operands, the immediate and control bits from decode;
- a combinational 4-function ALU with an operand-B mux;
- the EX→MEM pipeline register, which forwards the ALU result, store data and the memory/write-back controls to the memory stage.

Branch and flag-setting controls are exposed at the EX stage for the branch/flag logic downstream.

## Interface
- N, default 32, datapath width for operands, immediate and result.

Clock and reset:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset of both pipeline registers.

ID→EX inputs:
- RD1_i  in  N  register operand A from decode.
- RD2_i  in  N  register operand B / store data from decode.
- Extend_i  in  N  sign/zero-extended immediate.
- A3_i  in  4  destination register index.
- RF_WE_i  in  1  register-file write enable.
- BranchSelect_i  in  1  branch select control.
- ALUOpBSelect_i  in  1  ALU operand-B source select (0 = RD2, 1 = Extend).
- ALUControl_i  in  2  ALU function code.
- SetFlags_i  in  1  flag-update request.
- MemWE_i  in  1  data-memory write enable.
- WBSelect_i  in  1  write-back source select.

EX-stage outputs:
- ALUResult_ex  out  N  combinational ALU result.
- ALUFlags_ex  out  2  combinational flags {Neg, Zero}.
- BranchSelect_ex  out  1  registered BranchSelect.
- SetFlags_ex  out  1  registered SetFlags.

MEM-stage outputs (EX→MEM register):
- AluResult_o  out  N  registered ALU result.
- RD2_o  out  N  registered store data.
- A3_o  out  4  registered destination index.
- RF_WE_o, MemWE_o, WBSelect_o  out  1 each  registered controls.

## Operation
- ID→EX register: on each rising CLK edge it captures every *_i input.
- ALU operand selection:
  - A = registered RD1.
  - B = registered Extend when the registered ALUOpBSelect is 1, otherwise registered RD2.
- ALUControl encoding:
  - 00: A + B.
  - 01: A − B (two's complement).
  - 10: A & B.
  - 11: A | B.
- ALU arithmetic width rules:
  - All operations are modulo 2^N; carry-out and overflow are discarded.
- Flags:
  - ALUFlags_ex[1] = ALUResult_ex[N-1] (negative).
  - ALUFlags_ex[0] = 1 when ALUResult_ex == 0 (zero).
  - Flags are produced every cycle regardless of SetFlags; SetFlags is only passed through.
- EX→MEM register: on each rising edge it captures:
  - ALUResult_ex;
  - registered RD2 (the store data is always RD2, even when B = Extend);
  - registered A3, RF_WE, MemWE and WBSelect.
- BranchSelect and SetFlags stop at the EX stage. They are not carried into EX→MEM.
- Stall and flush inputs: none. Both registers load every cycle.

## Timing
- Reset:
  - RST=1 clears all bits of both registers to 0 immediately, without waiting for CLK.
  - While RST is held, every registered output is 0.
  - ALUResult_ex is then 0 + 0 = 0 and ALUFlags_ex = 2'b01.
- Reset release: the first rising edge with RST=0 loads normally.
- Latency:
  - Inputs presented before edge k appear at the EX outputs after edge k.
  - The result appears on AluResult_o and the other MEM outputs after edge k+1, i.e. 2 cycles.
- Pipelining: a new operation may be accepted every cycle. Back-to-back operations appear on the MEM outputs on consecutive cycles.
- Reset mid-operation: any in-flight operation in either register is lost, and the outputs read 0 until new data is clocked in after release.

## Test plan
- Add:
  - Stimulus: RD1=1, RD2=3, ALUControl=00, ALUOpBSelect=0, other controls 0.
  - After edge 1: the registered RD1/RD2 equal 1/3, ALUResult_ex=4, ALUFlags_ex=00.
  - After edge 2: AluResult_o=4, RD2_o=3.
- Subtract negative and zero:
  - RD1=5, RD2=7, ALUControl=01: ALUResult_ex=0xFFFFFFFE, flags=10.
  - RD1=RD2=9: ALUResult_ex=0, flags=01.
- Logic and immediate:
  - RD1=0xF0F0F0F0, Extend=0x0FF00FF0, ALUOpBSelect=1.
  - ALUControl=10: 0x00F000F0.
  - ALUControl=11: 0xFFF0FFF0.
  - RD2_o still carries RD2.
- Wrap-around: RD1=0xFFFFFFFF, RD2=1, add → AluResult_o=0, Zero flag 1, no carry output.
- Control passthrough:
  - Stimulus: A3=0xA, RF_WE=1, MemWE=1, WBSelect=1, BranchSelect=1, SetFlags=1.
  - After edge 1: BranchSelect_ex=1 and SetFlags_ex=1.
  - After edge 2: A3_o=0xA and RF_WE_o, MemWE_o, WBSelect_o all 1.
- Async reset: assert RST between edges mid-stream → all registered outputs drop to 0 at once, AluResult_o=0 and ALUFlags_ex=01; after release, the next edge reloads the inputs.

Source files
------------

// File: rtl/ex_stage_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage_pipeline
//  Brief    : Execute-stage slice of the 32-bit pipelined datapath.
//             ID->EX register, operand-B mux + 4-function ALU with
//             {Neg, Zero} flags, and EX->MEM register.
//  Revision : 1.0  initial release
// ============================================================================
module ex_stage_pipeline #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RST,

    // ID->EX inputs from decode
    input  logic [N-1:0] RD1_i,
    input  logic [N-1:0] RD2_i,
    input  logic [N-1:0] Extend_i,
    input  logic [3:0]   A3_i,
    input  logic         RF_WE_i,
    input  logic         BranchSelect_i,
    input  logic         ALUOpBSelect_i,
    input  logic [1:0]   ALUControl_i,
    input  logic         SetFlags_i,
    input  logic         MemWE_i,
    input  logic         WBSelect_i,

    // EX-stage outputs
    output logic [N-1:0] ALUResult_ex,
    output logic [1:0]   ALUFlags_ex,
    output logic         BranchSelect_ex,
    output logic         SetFlags_ex,

    // MEM-stage outputs
    output logic [N-1:0] AluResult_o,
    output logic [N-1:0] RD2_o,
    output logic [3:0]   A3_o,
    output logic         RF_WE_o,
    output logic         MemWE_o,
    output logic         WBSelect_o
);

    localparam logic [1:0] C_ALU_ADD = 2'b00;
    localparam logic [1:0] C_ALU_SUB = 2'b01;
    localparam logic [1:0] C_ALU_AND = 2'b10;
    localparam logic [1:0] C_ALU_OR  = 2'b11;

    // ------------------------------------------------------------------
    // ID->EX register state
    // ------------------------------------------------------------------
    logic [N-1:0] id_rd1_q;
    logic [N-1:0] id_rd2_q;
    logic [N-1:0] id_ext_q;
    logic [3:0]   id_a3_q;
    logic         id_rf_we_q;
    logic         id_branch_q;
    logic         id_opb_sel_q;
    logic [1:0]   id_alu_ctl_q;
    logic         id_set_flags_q;
    logic         id_mem_we_q;
    logic         id_wb_sel_q;

    // ------------------------------------------------------------------
    // EX->MEM register state and its next-state values
    // ------------------------------------------------------------------
    logic [N-1:0] mem_alu_q,    mem_alu_d;
    logic [N-1:0] mem_rd2_q,    mem_rd2_d;
    logic [3:0]   mem_a3_q,     mem_a3_d;
    logic         mem_rf_we_q,  mem_rf_we_d;
    logic         mem_mem_we_q, mem_mem_we_d;
    logic         mem_wb_sel_q, mem_wb_sel_d;

    // ALU datapath
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_res;

    // ID->EX register: loads every decode output each cycle, no stall/flush
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            id_rd1_q       <= '0;
            id_rd2_q       <= '0;
            id_ext_q       <= '0;
            id_a3_q        <= '0;
            id_rf_we_q     <= 1'b0;
            id_branch_q    <= 1'b0;
            id_opb_sel_q   <= 1'b0;
            id_alu_ctl_q   <= '0;
            id_set_flags_q <= 1'b0;
            id_mem_we_q    <= 1'b0;
            id_wb_sel_q    <= 1'b0;
        end else begin
            id_rd1_q       <= RD1_i;
            id_rd2_q       <= RD2_i;
            id_ext_q       <= Extend_i;
            id_a3_q        <= A3_i;
            id_rf_we_q     <= RF_WE_i;
            id_branch_q    <= BranchSelect_i;
            id_opb_sel_q   <= ALUOpBSelect_i;
            id_alu_ctl_q   <= ALUControl_i;
            id_set_flags_q <= SetFlags_i;
            id_mem_we_q    <= MemWE_i;
            id_wb_sel_q    <= WBSelect_i;
        end
    end

    // Operand-B select and ALU; all arithmetic wraps modulo 2^N, carry dropped
    always_comb begin
        alu_b   = id_opb_sel_q ? id_ext_q : id_rd2_q;
        alu_res = '0;
        case (id_alu_ctl_q)
            C_ALU_ADD: alu_res = id_rd1_q + alu_b;
            C_ALU_SUB: alu_res = id_rd1_q - alu_b;
            C_ALU_AND: alu_res = id_rd1_q & alu_b;
            C_ALU_OR:  alu_res = id_rd1_q | alu_b;
            default:   alu_res = '0;
        endcase
    end

    // Flags are always computed; SetFlags only tells downstream whether to latch them
    assign ALUResult_ex    = alu_res;
    assign ALUFlags_ex     = {alu_res[N-1], (alu_res == '0)};
    assign BranchSelect_ex = id_branch_q;
    assign SetFlags_ex     = id_set_flags_q;

    // EX->MEM next state; store data is RD2 even when the ALU used the immediate
    always_comb begin
        mem_alu_d    = alu_res;
        mem_rd2_d    = id_rd2_q;
        mem_a3_d     = id_a3_q;
        mem_rf_we_d  = id_rf_we_q;
        mem_mem_we_d = id_mem_we_q;
        mem_wb_sel_d = id_wb_sel_q;
    end

    // EX->MEM register: branch/flag controls terminate at EX and are not carried
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_alu_q    <= '0;
            mem_rd2_q    <= '0;
            mem_a3_q     <= '0;
            mem_rf_we_q  <= 1'b0;
            mem_mem_we_q <= 1'b0;
            mem_wb_sel_q <= 1'b0;
        end else begin
            mem_alu_q    <= mem_alu_d;
            mem_rd2_q    <= mem_rd2_d;
            mem_a3_q     <= mem_a3_d;
            mem_rf_we_q  <= mem_rf_we_d;
            mem_mem_we_q <= mem_mem_we_d;
            mem_wb_sel_q <= mem_wb_sel_d;
        end
    end

    assign AluResult_o = mem_alu_q;
    assign RD2_o       = mem_rd2_q;
    assign A3_o        = mem_a3_q;
    assign RF_WE_o     = mem_rf_we_q;
    assign MemWE_o     = mem_mem_we_q;
    assign WBSelect_o  = mem_wb_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage_pipeline
//  Brief    : Scoreboard bench for ex_stage_pipeline. Directed vectors carry
//             hand-computed results; a monitor pops them as they emerge at
//             the EX stage and at the MEM stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage_pipeline;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [1:0]  ctl;
        logic        opb;
        logic [3:0]  a3;
        logic        rf_we;
        logic        mem_we;
        logic        wb_sel;
        logic        br;
        logic        setf;
        logic [31:0] exp_res;
        logic [1:0]  exp_flags;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] rd1_i, rd2_i, ext_i;
    logic [3:0]  a3_i;
    logic        rf_we_i, br_i, opb_i, setf_i, mem_we_i, wb_sel_i;
    logic [1:0]  ctl_i;

    logic [31:0] alu_res_ex;
    logic [1:0]  alu_flags_ex;
    logic        br_ex, setf_ex;
    logic [31:0] alu_res_o, rd2_o;
    logic [3:0]  a3_o;
    logic        rf_we_o, mem_we_o, wb_sel_o;

    int checks = 0;
    int errors = 0;

    vec_t ex_q[$];
    vec_t mem_q[$];
    logic valid_in;
    logic v_ex, v_mem;

    ex_stage_pipeline #(.N(32)) dut (
        .CLK             (clk),
        .RST             (rst),
        .RD1_i           (rd1_i),
        .RD2_i           (rd2_i),
        .Extend_i        (ext_i),
        .A3_i            (a3_i),
        .RF_WE_i         (rf_we_i),
        .BranchSelect_i  (br_i),
        .ALUOpBSelect_i  (opb_i),
        .ALUControl_i    (ctl_i),
        .SetFlags_i      (setf_i),
        .MemWE_i         (mem_we_i),
        .WBSelect_i      (wb_sel_i),
        .ALUResult_ex    (alu_res_ex),
        .ALUFlags_ex     (alu_flags_ex),
        .BranchSelect_ex (br_ex),
        .SetFlags_ex     (setf_ex),
        .AluResult_o     (alu_res_o),
        .RD2_o           (rd2_o),
        .A3_o            (a3_o),
        .RF_WE_o         (rf_we_o),
        .MemWE_o         (mem_we_o),
        .WBSelect_o      (wb_sel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tracks which stage holds a scored operation (one and two edges after issue)
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
        end else begin
            v_ex  <= valid_in;
            v_mem <= v_ex;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] ext, input logic [1:0] ctl,
                                input logic opb, input logic [3:0] a3,
                                input logic rf_we, input logic mem_we,
                                input logic wb_sel, input logic br, input logic setf,
                                input logic [31:0] exp_res, input logic [1:0] exp_flags);
        vec_t v;
        v.rd1 = rd1; v.rd2 = rd2; v.ext = ext; v.ctl = ctl; v.opb = opb;
        v.a3 = a3; v.rf_we = rf_we; v.mem_we = mem_we; v.wb_sel = wb_sel;
        v.br = br; v.setf = setf; v.exp_res = exp_res; v.exp_flags = exp_flags;
        return v;
    endfunction

    task automatic drive_zero();
        rd1_i = '0; rd2_i = '0; ext_i = '0; a3_i = '0; ctl_i = '0;
        rf_we_i = 0; br_i = 0; opb_i = 0; setf_i = 0; mem_we_i = 0; wb_sel_i = 0;
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        rd1_i = v.rd1; rd2_i = v.rd2; ext_i = v.ext; ctl_i = v.ctl; opb_i = v.opb;
        a3_i = v.a3; rf_we_i = v.rf_we; mem_we_i = v.mem_we; wb_sel_i = v.wb_sel;
        br_i = v.br; setf_i = v.setf;
        valid_in = 1'b1;
        ex_q.push_back(v);
        mem_q.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_alu_ex"},   alu_res_ex,   32'h0);
        chk({tag, "_flags_ex"}, {30'h0, alu_flags_ex}, 32'h1);
        chk({tag, "_br_ex"},    {31'h0, br_ex},   32'h0);
        chk({tag, "_setf_ex"},  {31'h0, setf_ex}, 32'h0);
        chk({tag, "_alu_o"},    alu_res_o,    32'h0);
        chk({tag, "_rd2_o"},    rd2_o,        32'h0);
        chk({tag, "_ctl_o"},    {25'h0, a3_o, rf_we_o, mem_we_o, wb_sel_o}, 32'h0);
    endtask

    // Monitor: pops the scoreboard whenever a scored operation reaches EX or MEM
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (v_ex) begin
                if (ex_q.size() == 0) begin
                    chk("ex_underflow", 32'h1, 32'h0);
                end else begin
                    e = ex_q.pop_front();
                    chk("ex_result", alu_res_ex, e.exp_res);
                    chk("ex_flags",  {30'h0, alu_flags_ex}, {30'h0, e.exp_flags});
                    chk("ex_branch", {31'h0, br_ex},   {31'h0, e.br});
                    chk("ex_setf",   {31'h0, setf_ex}, {31'h0, e.setf});
                end
            end
            if (v_mem) begin
                if (mem_q.size() == 0) begin
                    chk("mem_underflow", 32'h1, 32'h0);
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_result", alu_res_o, e.exp_res);
                    chk("mem_rd2",    rd2_o,     e.rd2);
                    chk("mem_a3",     {28'h0, a3_o}, {28'h0, e.a3});
                    chk("mem_ctl",    {29'h0, rf_we_o, mem_we_o, wb_sel_o},
                                      {29'h0, e.rf_we, e.mem_we, e.wb_sel});
                end
            end
        end
    end

    // Stimulus
    initial begin
        vec_t tbl[9];
        int   wait_cnt;
        tbl[0] = mk(32'h1,        32'h3,        32'h0,        2'b00, 0, 4'h0, 0,0,0,0,0, 32'h4,        2'b00);
        tbl[1] = mk(32'h5,        32'h7,        32'h0,        2'b01, 0, 4'h0, 0,0,0,0,0, 32'hFFFFFFFE, 2'b10);
        tbl[2] = mk(32'h9,        32'h9,        32'h0,        2'b01, 0, 4'h0, 0,0,0,0,0, 32'h0,        2'b01);
        tbl[3] = mk(32'hF0F0F0F0, 32'h12345678, 32'h0FF00FF0, 2'b10, 1, 4'h0, 0,0,0,0,0, 32'h00F000F0, 2'b00);
        tbl[4] = mk(32'hF0F0F0F0, 32'h12345678, 32'h0FF00FF0, 2'b11, 1, 4'h0, 0,0,0,0,0, 32'hFFF0FFF0, 2'b10);
        tbl[5] = mk(32'hFFFFFFFF, 32'h1,        32'h0,        2'b00, 0, 4'h0, 0,0,0,0,0, 32'h0,        2'b01);
        tbl[6] = mk(32'h10,       32'h20,       32'h0,        2'b00, 0, 4'hA, 1,1,1,1,1, 32'h30,       2'b00);
        tbl[7] = mk(32'h64,       32'hDEADBEEF, 32'h64,       2'b01, 1, 4'h5, 1,0,0,0,1, 32'h0,        2'b01);
        tbl[8] = mk(32'hFFFF0000, 32'h80008000, 32'h0,        2'b10, 0, 4'h3, 0,1,0,1,0, 32'h80000000, 2'b10);

        valid_in = 1'b0;
        drive_zero();
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream of every vector
        foreach (tbl[i]) issue(tbl[i]);

        // Mid-stream async reset with two operations in flight
        issue(tbl[6]);
        issue(tbl[3]);
        @(negedge clk);
        valid_in = 1'b0;
        rd1_i = 32'h11111111; rd2_i = 32'h22222222; a3_i = 4'hF;
        rf_we_i = 1; br_i = 1; setf_i = 1; mem_we_i = 1; wb_sel_i = 1;
        #2;
        rst = 1'b1;
        ex_q.delete();
        mem_q.delete();
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_held");
        rst = 1'b0;
        issue(tbl[7]);
        issue(tbl[1]);

        @(negedge clk);
        valid_in = 1'b0;
        drive_zero();
        wait_cnt = 0;
        while ((ex_q.size() != 0 || mem_q.size() != 0) && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("drain_timeout", ex_q.size() + mem_q.size(), 32'h0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
